// File: rtl/display_pkg.sv
// Shared definitions for the display test-pattern path.
//   MODE_W / LEVEL_W : widths of the mode code and intensity level buses
//   state_t          : scheduler FSM states
//   MODE_*           : pattern mode codes, shared with the pattern generator
//   mode_succ()      : next mode in the auto-advance sequence, with wrap
package display_pkg;

  localparam int MODE_W  = 2;
  localparam int LEVEL_W = 4;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    SWITCH   = 2'd2,
    FADE_IN  = 2'd3
  } state_t;

  localparam logic [MODE_W-1:0] MODE_COLOR_BARS = 2'd0;
  localparam logic [MODE_W-1:0] MODE_GRID       = 2'd1;
  localparam logic [MODE_W-1:0] MODE_GRADIENT   = 2'd2;
  localparam logic [MODE_W-1:0] MODE_CHECKER    = 2'd3;

  // Wraps num_modes-1 back to 0; codes at or above num_modes also wrap.
  function automatic logic [MODE_W-1:0] mode_succ(input logic [MODE_W-1:0] m,
                                                  input int num_modes);
    return (int'(m) >= num_modes - 1) ? '0 : m + 1'b1;
  endfunction

endpackage

// File: rtl/frame_tick_div.sv
// Frame-pulse prescaler: emits one o_tick for every DIV qualified frame pulses.
//   i_clk   : pixel clock
//   i_rst_n : asynchronous active-low reset
//   i_frame : qualified frame pulse to count
//   i_clr   : synchronous clear of the count (suppresses o_tick)
//   o_tick  : combinational, high in the cycle of the DIV-th frame pulse
module frame_tick_div #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_frame,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign o_tick = i_frame & ~i_clr & (cnt == CW'(DIV - 1));

  // NOTE: every register is cleared by the async reset so the block leaves
  // reset in a known state without relying on a first frame pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clr || o_tick) begin
      cnt <= '0;
    end else if (i_frame) begin
      // NOTE: non-blocking assignment for all state so every flop samples the
      // pre-edge values regardless of statement order.
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_pattern_scheduler.sv
// Test-pattern scheduler: chooses the active pattern mode and global intensity.
// Mode changes are deferred to frame boundaries and wrapped in a fade-out /
// fade-in intensity ramp.
//   i_clk, i_rst_n     : pixel clock, asynchronous active-low reset
//   i_frame            : one pulse per frame (start of vblank)
//   i_next             : key pulse, advance to the next mode
//   i_cfg_valid/_mode/_hold, o_cfg_ready : CPU config handshake
//   o_mode             : active pattern mode
//   o_level            : intensity multiplier for the colour mixer
//   o_mode_changed     : one-cycle pulse when o_mode updates
//   o_busy             : high whenever a fade/switch is in progress
module display_pattern_scheduler
  import display_pkg::*;
#(
  parameter int NUM_MODES       = 4,
  parameter int DWELL_FRAMES    = 300,
  parameter int FRAMES_PER_STEP = 2,
  parameter int LEVEL_MAX       = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame,
  input  logic               i_next,
  input  logic               i_cfg_valid,
  input  logic [MODE_W-1:0]  i_cfg_mode,
  input  logic               i_cfg_hold,
  output logic               o_cfg_ready,
  output logic [MODE_W-1:0]  o_mode,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_mode_changed,
  output logic               o_busy
);

  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_ONE = LEVEL_W'(1);

  state_t             state, state_next;
  logic               pending;
  logic               hold;
  logic [MODE_W-1:0]  target;

  logic show_idle;
  logic cfg_accept;
  logic cfg_change;
  logic next_accept;
  logic dwell_tick;
  logic step_tick;
  logic in_fade;

  assign show_idle   = (state == SHOW) & ~pending;
  assign o_cfg_ready = show_idle;
  assign o_busy      = (state != SHOW);
  assign in_fade     = (state == FADE_OUT) | (state == FADE_IN);

  assign cfg_accept  = i_cfg_valid & show_idle;
  // Requests for the current mode or an unknown mode only update hold.
  assign cfg_change  = cfg_accept & (int'(i_cfg_mode) < NUM_MODES) &
                       (i_cfg_mode != o_mode);
  // A same-cycle config accept always takes precedence over the key.
  assign next_accept = i_next & show_idle & ~cfg_accept;

  // Dwell counts only idle SHOW frames; it restarts after every fade and
  // whenever a config request starts a new fade.
  frame_tick_div #(.DIV(DWELL_FRAMES)) u_dwell_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_frame (i_frame & show_idle & ~hold),
    .i_clr   ((state != SHOW) | cfg_change),
    .o_tick  (dwell_tick)
  );

  // Held at zero outside the fade states, so each fade starts a fresh count.
  frame_tick_div #(.DIV(FRAMES_PER_STEP)) u_step_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_frame (i_frame & in_fade),
    .i_clr   (~in_fade),
    .o_tick  (step_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= SHOW;
    else          state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    unique case (state)
      SHOW:     if (pending) state_next = FADE_OUT;
      FADE_OUT: if ((o_level == '0) || (step_tick && o_level == LVL_ONE))
                  state_next = SWITCH;
      SWITCH:   if (i_frame) state_next = FADE_IN;
      FADE_IN:  if ((o_level >= LVL_MAX) || (step_tick && o_level == LVL_MAX - 1'b1))
                  state_next = SHOW;
      default:  state_next = SHOW;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mode         <= MODE_COLOR_BARS;
      o_level        <= LVL_MAX;
      o_mode_changed <= 1'b0;
      pending        <= 1'b0;
      hold           <= 1'b0;
      target         <= '0;
    end else begin
      o_mode_changed <= 1'b0;

      if (cfg_accept) hold <= i_cfg_hold;

      if (cfg_change) begin
        target  <= i_cfg_mode;
        pending <= 1'b1;
      end else if (next_accept || dwell_tick) begin
        target  <= mode_succ(o_mode, NUM_MODES);
        pending <= 1'b1;
      end

      // Saturating ramps: the level never wraps even if a tick arrives late.
      if (state == FADE_OUT && step_tick && o_level != '0)
        o_level <= o_level - 1'b1;
      if (state == FADE_IN && step_tick && o_level != LVL_MAX)
        o_level <= o_level + 1'b1;

      if (state == SWITCH && i_frame) begin
        o_mode         <= target;
        o_mode_changed <= 1'b1;
        pending        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_pattern_scheduler.sv
// Directed bench for display_pattern_scheduler with short dwell and fades
// (DWELL_FRAMES=4, FRAMES_PER_STEP=1, LEVEL_MAX=3, NUM_MODES=4).
module tb_display_pattern_scheduler;

  localparam int LMAX = 3;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_frame = 1'b0;
  logic       i_next = 1'b0;
  logic       i_cfg_valid = 1'b0;
  logic [1:0] i_cfg_mode = 2'd0;
  logic       i_cfg_hold = 1'b0;
  logic       o_cfg_ready;
  logic [1:0] o_mode;
  logic [3:0] o_level;
  logic       o_mode_changed;
  logic       o_busy;

  int n_vec = 0;
  int n_err = 0;

  display_pattern_scheduler #(
    .NUM_MODES       (4),
    .DWELL_FRAMES    (4),
    .FRAMES_PER_STEP (1),
    .LEVEL_MAX       (LMAX)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_frame        (i_frame),
    .i_next         (i_next),
    .i_cfg_valid    (i_cfg_valid),
    .i_cfg_mode     (i_cfg_mode),
    .i_cfg_hold     (i_cfg_hold),
    .o_cfg_ready    (o_cfg_ready),
    .o_mode         (o_mode),
    .o_level        (o_level),
    .o_mode_changed (o_mode_changed),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame pulse; chg is o_mode_changed just after the frame edge,
  // chg2 one cycle later. Returns at a falling edge with one idle cycle spare.
  task automatic pulse_frame(output logic chg, output logic chg2);
    @(negedge i_clk); i_frame = 1'b1;
    @(negedge i_clk); i_frame = 1'b0; chg = o_mode_changed;
    @(negedge i_clk); chg2 = o_mode_changed;
    @(negedge i_clk);
  endtask

  task automatic show_frames(input int n, input logic [1:0] exp_mode, input string tag);
    logic c, c2, any_chg;
    any_chg = 1'b0;
    for (int i = 0; i < n; i++) begin
      pulse_frame(c, c2);
      any_chg = any_chg | c | c2;
    end
    check({tag, "_mode"}, o_mode, exp_mode);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_nochg"}, any_chg, 1'b0);
    check({tag, "_level"}, o_level, LMAX);
  endtask

  task automatic cfg_req(input logic [1:0] mode, input logic hold, input logic nxt,
                         input logic exp_ready, input string tag);
    @(negedge i_clk);
    check({tag, "_ready_pre"}, o_cfg_ready, 1'b1);
    i_cfg_valid = 1'b1; i_cfg_mode = mode; i_cfg_hold = hold; i_next = nxt;
    @(negedge i_clk);
    i_cfg_valid = 1'b0; i_next = 1'b0;
    check({tag, "_ready_post"}, o_cfg_ready, exp_ready);
  endtask

  // Entered with a fade pending or in progress at full level.
  task automatic fade(input logic [1:0] new_mode, input logic poke_next, input string tag);
    logic c, c2;
    for (int i = 0; i < LMAX; i++) begin
      pulse_frame(c, c2);
      check({tag, "_out_level"}, o_level, LMAX - 1 - i);
      check({tag, "_out_busy"}, o_busy, 1'b1);
      check({tag, "_out_nochg"}, c, 1'b0);
    end
    pulse_frame(c, c2);
    check({tag, "_sw_pulse"}, c, 1'b1);
    check({tag, "_sw_pulse_end"}, c2, 1'b0);
    check({tag, "_sw_mode"}, o_mode, new_mode);
    check({tag, "_sw_level"}, o_level, 0);
    for (int i = 0; i < LMAX; i++) begin
      pulse_frame(c, c2);
      check({tag, "_in_level"}, o_level, i + 1);
      check({tag, "_in_mode"}, o_mode, new_mode);
      if (poke_next && i == 0) begin
        i_next = 1'b1;
        @(negedge i_clk); i_next = 1'b0;
      end
    end
    @(negedge i_clk);
    check({tag, "_done_busy"}, o_busy, 1'b0);
    check({tag, "_done_ready"}, o_cfg_ready, 1'b1);
  endtask

  initial begin
    logic c, c2;

    // Reset values, including ready while reset is held.
    repeat (2) @(negedge i_clk);
    check("rst_ready", o_cfg_ready, 1'b1);
    check("rst_mode", o_mode, 0);
    check("rst_level", o_level, LMAX);
    check("rst_busy", o_busy, 1'b0);
    check("rst_chg", o_mode_changed, 1'b0);
    i_rst_n = 1'b1;

    // Auto-advance: three frames stay in SHOW, the fourth starts the fade.
    show_frames(3, 2'd0, "dwell3");
    pulse_frame(c, c2);
    check("dwell4_busy", o_busy, 1'b1);
    check("dwell4_level", o_level, LMAX);
    check("dwell4_ready", o_cfg_ready, 1'b0);
    check("dwell4_mode", o_mode, 0);
    fade(2'd1, 1'b0, "auto");

    // Config to mode 3 with hold: full fade, then no auto-advance.
    cfg_req(2'd3, 1'b1, 1'b0, 1'b0, "cfg3");
    fade(2'd3, 1'b0, "cfg3");
    show_frames(20, 2'd3, "hold20");

    // Back to mode 0, release hold; a key press mid fade-in is dropped.
    cfg_req(2'd0, 1'b0, 1'b0, 1'b0, "cfg0");
    fade(2'd0, 1'b1, "nextin");
    show_frames(3, 2'd0, "after_next");

    // Config and key in the same cycle: config target wins.
    cfg_req(2'd2, 1'b0, 1'b1, 1'b0, "race");
    fade(2'd2, 1'b0, "race");

    // Same-mode config: accepted, no fade, dwell count preserved.
    cfg_req(2'd0, 1'b0, 1'b0, 1'b0, "to0");
    fade(2'd0, 1'b0, "to0");
    show_frames(2, 2'd0, "pre_same");
    cfg_req(2'd0, 1'b0, 1'b0, 1'b1, "same");
    check("same_busy", o_busy, 1'b0);
    repeat (3) @(negedge i_clk);
    check("same_busy_later", o_busy, 1'b0);
    check("same_ready_later", o_cfg_ready, 1'b1);
    show_frames(1, 2'd0, "same_dwell3");
    pulse_frame(c, c2);
    check("same_dwell4_busy", o_busy, 1'b1);
    pulse_frame(c, c2);
    check("mid_level2", o_level, 2);
    pulse_frame(c, c2);
    check("mid_level1", o_level, 1);

    // Reset mid-fade returns to reset values immediately.
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("midrst_mode", o_mode, 0);
    check("midrst_level", o_level, LMAX);
    check("midrst_ready", o_cfg_ready, 1'b1);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_chg", o_mode_changed, 1'b0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    show_frames(3, 2'd0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
